// File: rtl/sub_serial_nbit_pkg.sv
// Shared definitions for the bit-serial N-bit subtractor: FSM states and default width.
package sub_serial_nbit_pkg;
  localparam int BIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sub_serial_nbit_fs.sv
// 1-bit full subtractor: diff = a - b - bin, bout set when a < b + bin.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/sub_serial_nbit.sv
// Bit-serial subtractor: one bit per cycle LSB first, result published on entry to DONE.
module sub_serial_nbit
  import sub_serial_nbit_pkg::*;
#(
  parameter int BIT = BIT_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [BIT-1:0] a_i,
  input  logic [BIT-1:0] b_i,
  input  logic           bin_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [BIT-1:0] diff_o,
  output logic           bout_o
);
  localparam int CW = (BIT > 1) ? $clog2(BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT - 1);

  state_t         state;
  logic [BIT-1:0] a_sh;
  logic [BIT-1:0] b_sh;
  logic [BIT-1:0] res;
  logic           br;
  logic [CW-1:0]  cnt;
  logic           d;
  logic           bo;

  fs u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .diff (d),
    .bout (bo)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      diff_o <= '0;
      bout_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sh   <= a_i;
            b_sh   <= b_i;
            br     <= bin_i;
            cnt    <= '0;
            res    <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= {d, res[BIT-1:1]};
          br   <= bo;
          if (cnt == LAST) begin
            // The last bit goes straight to the output so partial shifts never show.
            diff_o <= {d, res[BIT-1:1]};
            bout_o <= bo;
            busy_o <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule
